// File: rtl/glyph_renderer.sv
// Text-mode glyph renderer: 4-clock pipeline from sync-generator timing to rgb.
// Optional cursor overlay with a blinking frame counter is compiled in by `define CURSOR_EN.
module glyph_renderer #(
    parameter int ADDR_W  = 13,
    parameter int FONT_AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [10:0]        hpos,
    input  logic [9:0]         vpos,
    input  logic               display_on,
    input  logic               hsync,
    input  logic               vsync,
    output logic [ADDR_W-1:0]  char_addr,
    input  logic [13:0]        char_data,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [7:0]         font_data,
    input  logic [6:0]         cursor_col,
    input  logic [5:0]         cursor_row,
    output logic [5:0]         rgb,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o
);

    logic [3:0] hs_pipe, vs_pipe, de_pipe;
    logic [2:0] x1, x2, x3;
    logic [3:0] line1;
    logic [2:0] fg2, bg2, fg3, bg3;
    logic [7:0] font_q;
    logic       pix;
    logic       cursor_on;
    logic [2:0] colour;

    logic unused_hpos;
    assign unused_hpos = hpos[10];

    assign hsync_o = hs_pipe[3];
    assign vsync_o = vs_pipe[3];
    assign de_o    = de_pipe[3];

    always_comb begin
        pix    = font_q[3'd7 - x3];
        colour = (pix || cursor_on) ? fg3 : bg3;
    end

    // Memory data arrives the cycle after each registered address; every stage
    // carries its own copy of the pixel offset and colours so no bubbles appear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_pipe   <= '0;
            vs_pipe   <= '0;
            de_pipe   <= '0;
            char_addr <= '0;
            font_addr <= '0;
            x1        <= '0;
            x2        <= '0;
            x3        <= '0;
            line1     <= '0;
            fg2       <= '0;
            bg2       <= '0;
            fg3       <= '0;
            bg3       <= '0;
            font_q    <= '0;
            rgb       <= '0;
        end else begin
            hs_pipe   <= {hs_pipe[2:0], hsync};
            vs_pipe   <= {vs_pipe[2:0], vsync};
            de_pipe   <= {de_pipe[2:0], display_on};
            char_addr <= ADDR_W'({vpos[9:4], hpos[9:3]});
            x1        <= hpos[2:0];
            line1     <= vpos[3:0];
            font_addr <= FONT_AW'({char_data[7:0], line1});
            fg2       <= char_data[10:8];
            bg2       <= char_data[13:11];
            x2        <= x1;
            font_q    <= font_data;
            fg3       <= fg2;
            bg3       <= bg2;
            x3        <= x2;
            rgb       <= de_pipe[2] ? {colour[2], colour[2], colour[1], colour[1],
                                       colour[0], colour[0]} : 6'd0;
        end
    end

`ifdef CURSOR_EN
    logic [4:0] frame_cnt;
    logic [2:0] cur_pipe;
    logic       cur_hit;

    // Cursor is the bottom two lines of its cell; the hit is resolved at input
    // time and delayed so it lines up with the font line it overrides.
    assign cur_hit = (hpos[9:3] == cursor_col) && (vpos[9:4] == cursor_row) &&
                     (vpos[3:1] == 3'b111);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            cur_pipe  <= '0;
        end else begin
            if (hpos == 11'd0 && vpos == 10'd0)
                frame_cnt <= frame_cnt + 5'd1;
            cur_pipe <= {cur_pipe[1:0], cur_hit};
        end
    end

    assign cursor_on = cur_pipe[2] & ~frame_cnt[4];
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_col, cursor_row};
    assign cursor_on     = 1'b0;
`endif

endmodule

// File: tb/tb_glyph_renderer.sv
// Scoreboard bench for glyph_renderer: directed pixels, blanking, sync alignment,
// mid-line reset and cursor blink, with hand-computed rgb expectations.
module tb_glyph_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hpos;
    logic [9:0]  vpos;
    logic        display_on, hsync, vsync;
    logic [12:0] char_addr;
    logic [13:0] char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [5:0]  rgb;
    logic        hsync_o, vsync_o, de_o;

    logic [13:0] tram [0:8191];
    logic [7:0]  font [0:4095];

    assign char_data = tram[char_addr];
    assign font_data = font[font_addr];

    glyph_renderer #(.ADDR_W(13), .FONT_AW(12)) dut (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .hsync(hsync), .vsync(vsync),
        .char_addr(char_addr), .char_data(char_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [8:0] exp;
        logic       chk_addr;
        int         grp;
        int         id;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  failures = 0;
    int  nid = 0;
    int  grp = 0;

`ifdef CURSOR_EN
    localparam bit CUR = 1'b1;
`else
    localparam bit CUR = 1'b0;
`endif

    // Monitor: compares {rgb,hsync_o,vsync_o,de_o} whenever an entry is due.
    sb_t        ent;
    logic [8:0] got;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            ent = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL missed grp=%0d id=%0d due=%0d now=%0d", ent.grp, ent.id, ent.due, cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            ent = sb.pop_front();
            got = {rgb, hsync_o, vsync_o, de_o};
            checks++;
            if (got !== ent.exp) begin
                failures++;
                $display("FAIL pixel grp=%0d id=%0d cyc=%0d got rgb=%h hs=%b vs=%b de=%b exp rgb=%h hs=%b vs=%b de=%b",
                         ent.grp, ent.id, cyc, got[8:3], got[2], got[1], got[0],
                         ent.exp[8:3], ent.exp[2], ent.exp[1], ent.exp[0]);
            end
            if (ent.chk_addr) begin
                checks++;
                if (char_addr !== 13'd0 || font_addr !== 12'd0) begin
                    failures++;
                    $display("FAIL reset_addr got char_addr=%h font_addr=%h exp 0/0", char_addr, font_addr);
                end
            end
        end
    end

    // One pixel per call; rst flushes outputs already in flight.
    task automatic issue(input int h, input int v, input logic de, input logic hs,
                         input logic vs, input logic [5:0] exp_rgb, input logic rst);
        hpos       = h[10:0];
        vpos       = v[9:0];
        display_on = de;
        hsync      = hs;
        vsync      = vs;
        rst_n      = ~rst;
        if (rst) begin
            for (int i = 0; i < sb.size(); i++)
                if (sb[i].due > cyc) sb[i].exp = '0;
        end
        sb.push_back('{due: cyc + 4, exp: rst ? 9'd0 : {exp_rgb, hs, vs, de},
                       chk_addr: 1'b0, grp: grp, id: nid});
        nid++;
        @(posedge clk);
        #1;
    endtask

    int fc;
    logic [5:0] cexp;

    initial begin
        for (int i = 0; i < 8192; i++) tram[i] = '0;
        for (int i = 0; i < 4096; i++) font[i] = '0;
        tram[0]    = {3'b001, 3'b010, 8'h00};  // cell (0,0): blank, fg 2, bg 1
        tram[130]  = {3'b001, 3'b111, 8'h41};  // cell (2,1)
        tram[389]  = {3'b000, 3'b111, 8'h42};  // cell (5,3)
        tram[4863] = {3'b010, 3'b100, 8'h43};  // cell (127,37)
        font[12'h413] = 8'h80;
        for (int l = 0; l < 16; l++) font[12'h420 + l] = 8'hFF;
        font[12'h435] = 8'h0F;
        font[12'h437] = 8'h80;
        cursor_col = 7'd127;
        cursor_row = 6'd63;

        // Reset with live-looking inputs: outputs and addresses must be zero.
        rst_n = 1'b0; hpos = 11'd16; vpos = 10'd19; display_on = 1'b1;
        hsync = 1'b1; vsync = 1'b1;
        sb.push_back('{due: 1, exp: 9'd0, chk_addr: 1'b1, grp: 0, id: nid});
        nid++;
        @(posedge clk);
        #1;

        grp = 1;  // cell (2,1) line 3, font 0x80, fg 7 / bg 1
        for (int x = 0; x < 8; x++)
            issue(16 + x, 19, 1'b1, 1'b0, 1'b0, (x == 0) ? 6'h3F : 6'h03, 1'b0);
        issue(8, 19, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0);

        grp = 2;  // sync alignment: hsync width 3, vsync width 2, de pulse
        for (int i = 0; i < 6; i++)
            issue(200, 200, 1'b0, (i >= 1 && i <= 3), (i == 2 || i == 3), 6'h00, 1'b0);
        issue(200, 200, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0);
        issue(200, 200, 1'b0, 1'b0, 1'b1, 6'h00, 1'b0);

        grp = 3;  // blanking over a solid 0xFF glyph with fg 7
        issue(40, 50, 1'b1, 1'b0, 1'b0, 6'h3F, 1'b0);
        issue(41, 50, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
        issue(47, 50, 1'b1, 1'b0, 1'b0, 6'h3F, 1'b0);
        issue(44, 63, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0);

        grp = 4;  // column 127, partial row 37: fg 4 -> 0x30, bg 2 -> 0x0C
        issue(1016, 597, 1'b1, 1'b0, 1'b0, 6'h0C, 1'b0);
        issue(1020, 597, 1'b1, 1'b0, 1'b0, 6'h30, 1'b0);
        issue(1023, 597, 1'b1, 1'b0, 1'b0, 6'h30, 1'b0);
        issue(1016, 599, 1'b1, 1'b0, 1'b0, 6'h30, 1'b0);
        issue(1017, 599, 1'b1, 1'b0, 1'b0, 6'h0C, 1'b0);

        grp = 5;  // one-clock reset mid-line flushes three pixels already in flight
        for (int i = 0; i < 4; i++)
            issue(16, 19, 1'b1, 1'b1, 1'b0, 6'h3F, 1'b0);
        issue(16, 19, 1'b1, 1'b1, 1'b1, 6'h00, 1'b1);
        issue(16, 19, 1'b1, 1'b1, 1'b0, 6'h3F, 1'b0);
        issue(17, 19, 1'b1, 1'b0, 1'b0, 6'h03, 1'b0);

        grp = 6;  // cursor at (0,0) over blank glyph, fg 2 / bg 1
        cursor_col = 7'd0;
        cursor_row = 6'd0;
        issue(100, 100, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
        fc = 0;
        issue(3, 13, 1'b1, 1'b0, 1'b0, 6'h03, 1'b0);
        for (int f = 0; f < 34; f++) begin
            cexp = (CUR && fc < 16) ? 6'h0C : 6'h03;
            issue((f % 2 == 0) ? 3 : 7, (f % 2 == 0) ? 14 : 15, 1'b1, 1'b0, 1'b0, cexp, 1'b0);
            for (int p = 0; p < 3; p++)
                issue(100, 100, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
            issue(0, 0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
            fc = (fc + 1) % 32;
        end
        issue(8, 14, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0);

        hpos = 11'd100; vpos = 10'd100; display_on = 1'b0; hsync = 1'b0; vsync = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + sb.size());
        $finish;
    end

endmodule

// File: doc/glyph_renderer.md
GLYPH_RENDERER -- requirements
Module: glyph_renderer

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning text RAM address width = row bits (6) + column bits (7).
REQ-002 SHALL have parameter FONT_AW, default 12, meaning font ROM address width = glyph code (8) + glyph line (4).
REQ-003 clk  input  1  pixel clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 hpos  input  11  horizontal position from the sync generator.
REQ-006 vpos  input  10  vertical position from the sync generator.
REQ-007 display_on  input  1  active-area flag from the sync generator.
REQ-008 hsync, vsync  input  1 each  sync pulses from the sync generator, polarity already applied.
REQ-009 char_addr  output  ADDR_W  text RAM read address, equal to {vpos[9:4], hpos[9:3]}.
REQ-010 char_data  input  14  text RAM read data, valid exactly one cycle after char_addr: [7:0] glyph code, [10:8] fg colour, [13:11] bg colour.
REQ-011 font_addr  output  FONT_AW  font ROM address, equal to {glyph code, glyph line}.
REQ-012 font_data  input  8  font ROM line, valid exactly one cycle after font_addr; bit 7 is the leftmost pixel.
REQ-013 cursor_col  input  7  cursor column; cursor_row  input  6  cursor row (used only when CURSOR_EN is defined).
REQ-014 rgb  output  6  pixel colour {R1,R0,G1,G0,B1,B0}, registered.
REQ-015 hsync_o, vsync_o, de_o  output  1 each  sync and active-area flag, delayed to align with rgb.

Function
REQ-016 Glyph cell SHALL be 8 px wide by 16 lines high: column = hpos[9:3], x offset = hpos[2:0], row = vpos[9:4], line = vpos[3:0].
REQ-017 Pipeline SHALL be: T0 inputs sampled; T1 char_addr registered; T2 char_data returned, font_addr registered; T3 font_data returned; T4 rgb registered.
REQ-018 Total latency from hpos/vpos/display_on/hsync/vsync to rgb/hsync_o/vsync_o/de_o SHALL be exactly 4 clocks, with no bubbles and one pixel per clock.
REQ-019 x offset, line, display_on, hsync and vsync SHALL be carried through matching delay stages; fg/bg SHALL be registered at T2 and delayed to T4.
REQ-020 Pixel bit SHALL be font_data[7 - x offset]; rgb SHALL be fg when the bit is 1, else bg.
REQ-021 A 3-bit colour c SHALL expand to rgb = {c[2],c[2],c[1],c[1],c[0],c[0]}.
REQ-022 rgb SHALL be 0 whenever the delayed display_on (de_o) is 0, regardless of RAM/ROM data.
REQ-023 Columns 0..127 SHALL map to any hpos < 1024; a partial bottom row (e.g. 600 lines) SHALL render lines 0..7 of row 37 without special handling.
REQ-024 Addresses outside the active area are don't-care; the block SHALL NOT gate memory reads.

Reset
REQ-025 While rst_n = 0 at a rising edge, all pipeline registers, char_addr, font_addr, rgb, hsync_o, vsync_o, de_o and the frame counter SHALL become 0.
REQ-026 Reset mid-frame SHALL flush the pipeline; after rst_n returns to 1, outputs SHALL track inputs after exactly 4 clocks, with rgb = 0 until then.

Configuration
REQ-027 Macro CURSOR_EN SHALL compile in the cursor overlay; without it, cursor inputs are ignored and no frame counter exists.
REQ-028 With CURSOR_EN defined, a 5-bit frame counter SHALL increment on each clock where hpos = 0 and vpos = 0, wrapping 31 -> 0.
REQ-029 With CURSOR_EN defined, when frame counter bit 4 = 0 and the T4 pixel lies in cell (cursor_col, cursor_row) on line 14 or 15, rgb SHALL be fg regardless of the font bit (subject to REQ-022).

Verification
REQ-030 Alignment: drive hsync pulse at cycle N -> hsync_o pulses at N+4 with identical width; likewise vsync and display_on -> de_o.
REQ-031 Pixel: cell (2,1) holds code 0x41, fg=7, bg=1; font line 3 = 0x80 -> at hpos=16, vpos=19, rgb = 0x3F 4 clocks later; at hpos=17, rgb = 0x03.
REQ-032 Blanking: display_on = 0 with font_data = 0xFF and fg = 7 -> rgb = 0x00.
REQ-033 Reset: assert rst_n = 0 for 1 clock mid-line -> next edge all outputs 0; rgb valid again 4 clocks after release.
REQ-034 Cursor (CURSOR_EN): cursor at (0,0), blank glyph, fg = 2 -> frames 0..15 rgb = 0x0C on lines 14..15 of cell 0; frames 16..31 rgb = bg; frame counter wraps after frame 31.
